// File: rtl/audio_filter_ctrl.sv
// Codec-to-codec sample sequencer with a shared-datapath stereo moving-average filter.
// One running sum per channel is updated incrementally from a circular sample history.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for the codec to offer a sample pair
// READ    | pop strobe to the codec; sample pair already latched
// CALC_L  | left running-sum and history update
// CALC_R  | right running-sum and history update, advance shared pointer
// WAIT_WR | hold until the codec can take a pair, then load writedata
// WRITE   | push strobe to the codec
module audio_filter_ctrl #(
  parameter int FILTER_WIDTH = 3,
  parameter int DATA_WIDTH   = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  read_ready,
  input  logic                  write_ready,
  input  logic [DATA_WIDTH-1:0] readdata_left,
  input  logic [DATA_WIDTH-1:0] readdata_right,
  output logic                  read,
  output logic                  write,
  output logic [DATA_WIDTH-1:0] writedata_left,
  output logic [DATA_WIDTH-1:0] writedata_right,
  output logic                  busy
);

  localparam int DEPTH     = 1 << FILTER_WIDTH;
  localparam int SUM_WIDTH = DATA_WIDTH + FILTER_WIDTH;
  localparam logic [FILTER_WIDTH-1:0] PTR_ONE = FILTER_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CALC_L  = 3'd2,
    CALC_R  = 3'd3,
    WAIT_WR = 3'd4,
    WRITE   = 3'd5
  } state_t;

  state_t state;

  logic signed [DATA_WIDTH-1:0] sample_l;
  logic signed [DATA_WIDTH-1:0] sample_r;
  logic signed [DATA_WIDTH-1:0] hist_l [DEPTH];
  logic signed [DATA_WIDTH-1:0] hist_r [DEPTH];
  logic signed [SUM_WIDTH-1:0]  sum_l;
  logic signed [SUM_WIDTH-1:0]  sum_r;
  logic        [FILTER_WIDTH-1:0] ptr;

  function automatic logic signed [SUM_WIDTH-1:0] ext(input logic signed [DATA_WIDTH-1:0] v);
    return {{FILTER_WIDTH{v[DATA_WIDTH-1]}}, v};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      read            <= 1'b0;
      write           <= 1'b0;
      busy            <= 1'b0;
      writedata_left  <= '0;
      writedata_right <= '0;
      sample_l        <= '0;
      sample_r        <= '0;
      sum_l           <= '0;
      sum_r           <= '0;
      ptr             <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_l[i] <= '0;
        hist_r[i] <= '0;
      end
    end else begin
      read  <= 1'b0;
      write <= 1'b0;
      case (state)
        IDLE: begin
          if (read_ready) begin
            sample_l <= readdata_left;
            sample_r <= readdata_right;
            read     <= 1'b1;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          state <= CALC_L;
        end
        CALC_L: begin
          sum_l       <= sum_l + ext(sample_l) - ext(hist_l[ptr]);
          hist_l[ptr] <= sample_l;
          state       <= CALC_R;
        end
        CALC_R: begin
          sum_r       <= sum_r + ext(sample_r) - ext(hist_r[ptr]);
          hist_r[ptr] <= sample_r;
          ptr         <= ptr + PTR_ONE;
          state       <= WAIT_WR;
        end
        WAIT_WR: begin
          if (write_ready) begin
            // Upper DATA_WIDTH bits of the sum are the floor-divided average.
            if (enable) begin
              writedata_left  <= sum_l[SUM_WIDTH-1:FILTER_WIDTH];
              writedata_right <= sum_r[SUM_WIDTH-1:FILTER_WIDTH];
            end else begin
              writedata_left  <= sample_l;
              writedata_right <= sample_r;
            end
            write <= 1'b1;
            state <= WRITE;
          end
        end
        WRITE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_filter_ctrl.sv
// Self-checking bench for audio_filter_ctrl: directed scenarios plus randomized frames
// compared against a queue-based moving-average model.
module tb_audio_filter_ctrl;

  localparam int FW    = 3;
  localparam int DW    = 24;
  localparam int DEPTH = 1 << FW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          read_ready = 1'b0;
  logic          write_ready = 1'b0;
  logic [DW-1:0] readdata_left = '0;
  logic [DW-1:0] readdata_right = '0;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata_left;
  logic [DW-1:0] writedata_right;
  logic          busy;

  int errors = 0;
  int checks = 0;

  longint q_l[$];
  longint q_r[$];

  audio_filter_ctrl #(.FILTER_WIDTH(FW), .DATA_WIDTH(DW)) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .read_ready      (read_ready),
    .write_ready     (write_ready),
    .readdata_left   (readdata_left),
    .readdata_right  (readdata_right),
    .read            (read),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Window average with empty slots as zero, rounded toward minus infinity.
  function automatic longint window_avg(input longint q[$]);
    longint s = 0;
    longint d;
    foreach (q[i]) s += q[i];
    d = s / DEPTH;
    if ((s % DEPTH) != 0 && s < 0) d -= 1;
    return d;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    read_ready = 1'b0;
    write_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    q_l.delete();
    q_r.delete();
  endtask

  task automatic frame(input longint l, input longint r, input bit en, input int stall);
    longint el, er;
    bit     got;
    int     n;
    logic signed [DW-1:0] sl, sr;

    q_l.push_back(l);
    q_r.push_back(r);
    if (q_l.size() > DEPTH) void'(q_l.pop_front());
    if (q_r.size() > DEPTH) void'(q_r.pop_front());
    el = en ? window_avg(q_l) : l;
    er = en ? window_avg(q_r) : r;

    @(negedge clock);
    readdata_left  = l[DW-1:0];
    readdata_right = r[DW-1:0];
    read_ready     = 1'b1;
    enable         = en;
    write_ready    = (stall == 0);

    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      if (read) got = 1'b1;
    end
    check("read_seen", longint'(got), 1);
    if (!got) begin
      read_ready = 1'b0;
      return;
    end

    // Scramble the inputs so only the latched pair can produce the result.
    read_ready     = (stall > 0);
    readdata_left  = DW'($urandom);
    readdata_right = DW'($urandom);

    got = 1'b0;
    n = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clock);
      n = i;
      if (write) got = 1'b1;
      else if (stall > 0) begin
        check("stall_no_read", longint'(read), 0);
        check("stall_busy", longint'(busy), 1);
      end
      if (stall > 0 && i == stall) write_ready = 1'b1;
    end
    check("write_seen", longint'(got), 1);
    check("write_latency", n, (stall > 0) ? stall + 1 : 4);
    sl = writedata_left;
    sr = writedata_right;
    check("data_left", longint'(sl), el);
    check("data_right", longint'(sr), er);
    read_ready = 1'b0;
    @(negedge clock);
    check("write_one_cycle", longint'(write), 0);
  endtask

  initial begin
    logic signed [DW-1:0] rl, rr;
    int stall;

    do_reset();
    check("rst_read", longint'(read), 0);
    check("rst_write", longint'(write), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_wd_left", longint'(writedata_left), 0);
    check("rst_wd_right", longint'(writedata_right), 0);

    // Steady input ramps up over the window then saturates.
    for (int k = 0; k < 10; k++) frame(8, 16, 1'b1, 0);

    do_reset();
    frame(-1, 3, 1'b1, 0);
    for (int k = 0; k < 8; k++) frame(0, 0, 1'b1, 0);

    // Backpressure with read_ready held high during the stall.
    frame(100, -100, 1'b1, 10);

    do_reset();
    for (int k = 1; k <= 8; k++) frame(80 * k, -5 * k, 1'b0, 0);
    frame(720, 7, 1'b1, 0);

    do_reset();
    for (int k = 0; k < 8; k++) frame(longint'(8388607), longint'(-8388608), 1'b1, 0);
    for (int k = 0; k < 8; k++) frame(longint'(-8388608), longint'(8388607), 1'b1, 0);

    // Reset landing in CALC_L of the third frame.
    do_reset();
    frame(8, 8, 1'b1, 0);
    frame(8, 8, 1'b1, 0);
    @(negedge clock);
    readdata_left = 8;
    readdata_right = 8;
    read_ready = 1'b1;
    begin
      bit got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clock);
        if (read) got = 1'b1;
      end
      check("mid_read_seen", longint'(got), 1);
    end
    @(negedge clock);
    reset = 1'b1;
    read_ready = 1'b0;
    @(negedge clock);
    check("mid_rst_read", longint'(read), 0);
    check("mid_rst_write", longint'(write), 0);
    check("mid_rst_busy", longint'(busy), 0);
    reset = 1'b0;
    q_l.delete();
    q_r.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("mid_no_write", longint'(write), 0);
    end
    frame(8, 8, 1'b1, 0);

    // Randomized frames: random data, enable and occasional backpressure.
    for (int k = 0; k < 40; k++) begin
      rl = DW'($urandom);
      rr = DW'($urandom);
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 7)) : 0;
      frame(longint'(rl), longint'(rr), 1'($urandom_range(0, 1)), stall);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
